// File: rtl/mmm_pkg.sv
// ----------------------------------------------------------------------------
// mmm_pkg
// Shared definitions for the Montgomery modular-exponentiation slice:
//   - default operand/modulus width, exponent width and multiplier latency
//   - FSM state encoding used by mmm_modexp_ctrl
//   - helper to size the exponent bit index
// ----------------------------------------------------------------------------
package mmm_pkg;

    localparam int MMM_IDW = 256;
    localparam int MMM_EW  = 256;
    localparam int MMM_LAT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV_X = 3'd1,
        ST_CONV_A = 3'd2,
        ST_SQR    = 3'd3,
        ST_MUL    = 3'd4,
        ST_FROM   = 3'd5,
        ST_DONE   = 3'd6
    } mmm_state_e;

    // Width of an index able to address every exponent bit (at least 1 bit).
    function automatic int idx_width(input int ew);
        int w;
        if (ew > 1) begin
            w = $clog2(ew);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mmm_modexp_ctrl.sv
// ----------------------------------------------------------------------------
// mmm_modexp_ctrl
// Left-to-right square-and-multiply sequencer around an external Montgomery
// multiplier MM(a,b) = a*b*R^-1 mod m, R = 2^(IDW+3).
//   result = MM(MM-ladder over exp bits starting from MM(1,r2), x), 1)
//   with x = MM(base, r2) the Montgomery form of the base.
// Every multiplier operation lasts exactly LAT+1 cycles; all exponent bits are
// processed, so latency depends only on popcount(exp).
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               start request (only honoured in IDLE)
//   i_base, i_exp, i_m    base (< m), exponent, odd modulus
//   i_m_b                 multiplier modulus constant, passed through
//   i_r2                  R^2 mod m
//   o_mul_a/b/m/m_b       registered operands towards the multiplier
//   i_mul_res             multiplier result, valid LAT cycles after operands
//   o_busy                high from accept through the DONE cycle
//   o_done                one-cycle completion pulse (the DONE cycle)
//   o_res                 base^exp mod m, held until the next o_done
// ----------------------------------------------------------------------------
module mmm_modexp_ctrl
    import mmm_pkg::*;
#(
    parameter int IDW = MMM_IDW,
    parameter int EW  = MMM_EW,
    parameter int LAT = MMM_LAT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [IDW-1:0]   i_base,
    input  logic [EW-1:0]    i_exp,
    input  logic [IDW-1:0]   i_m,
    input  logic [IDW+2:0]   i_m_b,
    input  logic [IDW-1:0]   i_r2,
    output logic [IDW-1:0]   o_mul_a,
    output logic [IDW-1:0]   o_mul_b,
    output logic [IDW-1:0]   o_mul_m,
    output logic [IDW+2:0]   o_mul_m_b,
    input  logic [IDW-1:0]   i_mul_res,
    output logic             o_busy,
    output logic             o_done,
    output logic [IDW-1:0]   o_res
);

    localparam int             IXW     = idx_width(EW);
    localparam logic [IXW-1:0] IDX_TOP = IXW'(EW - 1);
    localparam logic [IXW-1:0] IDX_0   = {IXW{1'b0}};
    localparam logic [IXW-1:0] IDX_1   = IXW'(1);
    localparam logic [3:0]     LAT_W   = 4'(LAT);
    localparam logic [IDW-1:0] ONE     = IDW'(1);

    mmm_state_e       state_r,   state_s;
    logic [IXW-1:0]   idx_r,     idx_s;
    logic [3:0]       wcnt_r,    wcnt_s;
    logic [IDW-1:0]   mul_a_r,   mul_a_s;
    logic [IDW-1:0]   mul_b_r,   mul_b_s;
    logic [IDW-1:0]   mul_m_r,   mul_m_s;
    logic [IDW+2:0]   mul_m_b_r, mul_m_b_s;
    logic [IDW-1:0]   x_r,       x_s;
    logic [IDW-1:0]   r2_r,      r2_s;
    logic [EW-1:0]    exp_r,     exp_s;
    logic [IDW-1:0]   res_r,     res_s;
    logic             done_r,    done_s;
    logic             busy_r,    busy_s;
    logic             op_end_s;
    logic             last_bit_s;

    // Next-state and next-register computation for the exponentiation FSM.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        wcnt_s     = wcnt_r;
        mul_a_s    = mul_a_r;
        mul_b_s    = mul_b_r;
        mul_m_s    = mul_m_r;
        mul_m_b_s  = mul_m_b_r;
        x_s        = x_r;
        r2_s       = r2_r;
        exp_s      = exp_r;
        res_s      = res_r;
        done_s     = 1'b0;
        op_end_s   = (wcnt_r == LAT_W);
        last_bit_s = (idx_r == IDX_0);

        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    // Operands are loaded straight from the inputs so the first
                    // multiplication starts in the first busy cycle.
                    state_s   = ST_CONV_X;
                    idx_s     = IDX_TOP;
                    wcnt_s    = 4'd0;
                    mul_a_s   = i_base;
                    mul_b_s   = i_r2;
                    mul_m_s   = i_m;
                    mul_m_b_s = i_m_b;
                    r2_s      = i_r2;
                    exp_s     = i_exp;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CONV_X: begin
                if (op_end_s) begin
                    x_s     = i_mul_res;
                    state_s = ST_CONV_A;
                    wcnt_s  = 4'd0;
                    mul_a_s = ONE;
                    mul_b_s = r2_r;
                end else begin
                    wcnt_s = wcnt_r + 4'd1;
                end
            end

            ST_CONV_A: begin
                if (op_end_s) begin
                    state_s = ST_SQR;
                    wcnt_s  = 4'd0;
                    mul_a_s = i_mul_res;
                    mul_b_s = i_mul_res;
                end else begin
                    wcnt_s = wcnt_r + 4'd1;
                end
            end

            ST_SQR: begin
                if (op_end_s) begin
                    wcnt_s  = 4'd0;
                    mul_a_s = i_mul_res;
                    if (exp_r[idx_r]) begin
                        state_s = ST_MUL;
                        mul_b_s = x_r;
                    end else if (last_bit_s) begin
                        state_s = ST_FROM;
                        mul_b_s = ONE;
                    end else begin
                        state_s = ST_SQR;
                        idx_s   = idx_r - IDX_1;
                        mul_b_s = i_mul_res;
                    end
                end else begin
                    wcnt_s = wcnt_r + 4'd1;
                end
            end

            ST_MUL: begin
                if (op_end_s) begin
                    wcnt_s  = 4'd0;
                    mul_a_s = i_mul_res;
                    if (last_bit_s) begin
                        state_s = ST_FROM;
                        mul_b_s = ONE;
                    end else begin
                        state_s = ST_SQR;
                        idx_s   = idx_r - IDX_1;
                        mul_b_s = i_mul_res;
                    end
                end else begin
                    wcnt_s = wcnt_r + 4'd1;
                end
            end

            ST_FROM: begin
                if (op_end_s) begin
                    wcnt_s  = 4'd0;
                    res_s   = i_mul_res;
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    wcnt_s = wcnt_r + 4'd1;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                wcnt_s  = 4'd0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and datapath registers; reset abandons any running operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= IDX_0;
            wcnt_r    <= 4'd0;
            mul_a_r   <= {IDW{1'b0}};
            mul_b_r   <= {IDW{1'b0}};
            mul_m_r   <= {IDW{1'b0}};
            mul_m_b_r <= {(IDW+3){1'b0}};
            x_r       <= {IDW{1'b0}};
            r2_r      <= {IDW{1'b0}};
            exp_r     <= {EW{1'b0}};
            res_r     <= {IDW{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            wcnt_r    <= wcnt_s;
            mul_a_r   <= mul_a_s;
            mul_b_r   <= mul_b_s;
            mul_m_r   <= mul_m_s;
            mul_m_b_r <= mul_m_b_s;
            x_r       <= x_s;
            r2_r      <= r2_s;
            exp_r     <= exp_s;
            res_r     <= res_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
        end
    end

    assign o_mul_a   = mul_a_r;
    assign o_mul_b   = mul_b_r;
    assign o_mul_m   = mul_m_r;
    assign o_mul_m_b = mul_m_b_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_res     = res_r;

endmodule

// File: doc/mmm_modexp_ctrl.md
MMM_MODEXP_CTRL -- requirements
Module: mmm_modexp_ctrl

Interface
REQ-001 SHALL have parameter IDW, default 256, operand/modulus width.
REQ-002 SHALL have parameter EW, default 256, exponent width.
REQ-003 SHALL have parameter LAT, default 4, multiplier latency: cycles from operands presented to i_mul_res valid; legal 1..15.
REQ-004 SHALL have the following ports:
- i_clk  in  1  clock; one clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  start request, sampled only in IDLE.
- i_base  in  IDW  base, < m.
- i_exp  in  EW  exponent.
- i_m  in  IDW  odd modulus.
- i_m_b  in  IDW+3  multiplier precomputed modulus constant, passed through.
- i_r2  in  IDW  R^2 mod m, with R = 2^(IDW+3).
- o_mul_a  out  IDW  multiplier operand A.
- o_mul_b  out  IDW  multiplier operand B.
- o_mul_m  out  IDW  multiplier modulus.
- o_mul_m_b  out  IDW+3  multiplier modulus constant.
- i_mul_res  in  IDW  multiplier result, MM(a,b) = a*b*R^-1 mod m.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle completion pulse.
- o_res  out  IDW  base^exp mod m, valid from o_done, held until next o_done.

Function
REQ-005 SHALL register i_base, i_exp, i_m, i_m_b and i_r2 on the edge that accepts i_start; later input changes have no effect on the running operation.
REQ-006 SHALL drive o_mul_* only from internal registers, stable for the whole of each multiplier operation.
REQ-007 SHALL use FSM states IDLE, CONV_X, CONV_A, SQR, MUL, FROM, DONE.
REQ-008 SHALL leave IDLE for CONV_X on i_start=1; o_busy=1 in every state except IDLE.
REQ-009 SHALL run each non-IDLE/DONE state as one multiplier operation of exactly LAT+1 cycles: operands presented in the first cycle, i_mul_res captured at the end of cycle LAT+1, tracked by a 4-bit wait counter.
REQ-010 SHALL compute in CONV_X: x = MM(base, r2); in CONV_A: acc = MM(1, r2).
REQ-011 SHALL keep bit index idx, initialised to EW-1 and processed MSB to LSB.
REQ-012 SHALL compute in SQR: acc = MM(acc, acc); then go to MUL if exp[idx]=1, else to idx handling.
REQ-013 SHALL compute in MUL: acc = MM(acc, x), then go to idx handling.
REQ-014 SHALL, on idx handling, go to FROM if idx=0; otherwise decrement idx and go to SQR.
REQ-015 SHALL compute in FROM: o_res = MM(acc, 1), then go to DONE.
REQ-016 SHALL in DONE assert o_done for exactly one cycle, then return to IDLE; o_busy=1 during DONE.
REQ-017 SHALL process all EW bits; leading zeros are not skipped, so latency depends only on popcount(exp).
REQ-018 SHALL make the accept-to-o_done latency exactly (3+EW+popcount(exp))*(LAT+1)+1 cycles.
REQ-019 SHALL ignore i_start while busy, including during DONE; a new start is accepted only from IDLE.
REQ-020 SHALL produce o_res=1 for exp=0, and o_res=base for exp=1 (base<m); no special-case path for either.

Reset
REQ-021 SHALL on i_rst (asynchronous, at any time, including mid-operation) force the FSM to IDLE, o_busy=0, o_done=0, and clear to 0: o_res, o_mul_a, o_mul_b, o_mul_m, o_mul_m_b, idx and the wait counter.
REQ-022 SHALL, after reset releases mid-operation, produce no o_done for the aborted operation.

Structure
REQ-023 SHALL take the FSM state encoding, and the default IDW/EW/LAT values, from the shared mmm package.
REQ-024 SHALL keep the multiplier (mmm_nlp_256b_3way) external, paired with this block at the next level up; no sub-module is required inside.

Verification
REQ-025 SHALL cover these directed scenarios, using a bench multiplier model of latency LAT and the secp256k1 prime m = 2^256 - 2^32 - 977:
- EW=4, LAT=4, base=3, exp=0x5 -> o_res=243; o_done exactly 46 cycles after the accept edge.
- EW=4, exp=0, base=7 -> o_res=1; latency 36 cycles.
- EW=256, base=0xf913b410fe0d6b547a64ce68e9b7430214e56ec57e37d50dc22be4fe5e5f8d2f, exp=m-1 -> o_res=1 (Fermat).
- i_start pulsed every cycle during a run -> exactly one o_done; o_res matches the first operands only.
- i_rst asserted in SQR with idx=2 -> o_busy=0 immediately; no o_done; next start with base=2, exp=3 -> o_res=8.
- Inputs changed the cycle after accept -> result uses the latched values.
